// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: port count, select and
// hold-counter widths, FSM state encoding and the arbitration result type.
package rr_mux_arbiter_pkg;

    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/rr_mux_arbiter_mux4_w.sv
// WIDTH-bit 4:1 mux built as two levels of 2:1 selection.
module mux4_w
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [N_REQ*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       y
);

    logic [WIDTH-1:0] lo_pair;
    logic [WIDTH-1:0] hi_pair;

    assign lo_pair = sel[0] ? d[1*WIDTH +: WIDTH] : d[0*WIDTH +: WIDTH];
    assign hi_pair = sel[0] ? d[3*WIDTH +: WIDTH] : d[2*WIDTH +: WIDTH];
    assign y       = sel[1] ? hi_pair : lo_pair;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters, with a
// per-grant hold limit so a busy owner cannot starve the other ports.
//
//  state | meaning
//  IDLE  | no owner; gnt=0, arbitrate from ptr whenever any req is high
//  BUSY  | port sel owns the mux; hold until req drops or the hold limit hits
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] d,
    output logic [N_REQ-1:0]       gnt,
    output logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       y,
    output logic                   y_valid
);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [SEL_W-1:0]  search_start;
    pick_t             pick;
    logic              release_grant;
    logic [WIDTH-1:0]  mux_y;

    // First requester at or after start, wrapping; start itself is checked first.
    function automatic pick_t rr_search(input logic [N_REQ-1:0] r,
                                        input logic [SEL_W-1:0] start);
        pick_t            p;
        logic [SEL_W-1:0] idx;
        p = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (r[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    // On release the search starts just past the owner, so the owner is
    // considered last and wins again only if it still requests.
    always_comb begin
        search_start  = (state == BUSY) ? sel + SEL_W'(1) : ptr;
        pick          = rr_search(req, search_start);
        release_grant = !req[sel] || (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick.found) begin
                        state    <= BUSY;
                        gnt      <= N_REQ'(1) << pick.idx;
                        sel      <= pick.idx;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (release_grant) begin
                        ptr <= sel + SEL_W'(1);
                        if (pick.found) begin
                            gnt      <= N_REQ'(1) << pick.idx;
                            sel      <= pick.idx;
                            hold_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    mux4_w #(.WIDTH(WIDTH)) u_mux (
        .d   (d),
        .sel (sel),
        .y   (mux_y)
    );

    assign y_valid = |gnt;
    assign y       = mux_y & {WIDTH{y_valid}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and randomized checks of rr_mux_arbiter against an owner/pointer
// reference model evaluated once per clock.
module tb_rr_mux_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           req;
    logic [4*WIDTH-1:0]   d;
    logic [3:0]           gnt;
    logic [1:0]           sel;
    logic [WIDTH-1:0]     y;
    logic                 y_valid;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: owner index (-1 = none), pointer, cycles held so far
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_sel   = 0;

    rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic grant_new(input logic [3:0] r);
        m_owner = first_from(m_ptr, r);
        if (m_owner >= 0) begin
            m_held = 1;
            m_sel  = m_owner;
        end
    endtask

    task automatic tick(input logic rn, input logic [3:0] r, input logic [4*WIDTH-1:0] dv);
        logic [WIDTH-1:0] exp_y;
        rst_n = rn;
        req   = r;
        d     = dv;
        @(posedge clk);
        if (!rn) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            grant_new(r);
        end else if (!r[m_owner] || m_held == MAX_HOLD) begin
            m_ptr = (m_owner + 1) % 4;
            grant_new(r);
        end else begin
            m_held++;
        end
        #1;
        exp_y = (m_owner >= 0) ? WIDTH'(dv >> (WIDTH * m_owner)) : '0;
        chk("gnt",     32'(gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("sel",     32'(sel),     32'(m_sel));
        chk("y_valid", 32'(y_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("y",       32'(y),       32'(exp_y));
        chk("ptr",     32'(dut.ptr), 32'(m_ptr));
        if (m_owner >= 0) chk("hold_cnt", 32'(dut.hold_cnt), 32'(m_held - 1));
    endtask

    initial begin
        logic [3:0]         r;
        logic [4*WIDTH-1:0] dv;

        rst_n = 1'b0;
        req   = '0;
        d     = '0;

        // reset with all ports requesting, then first grant goes to port 0
        tick(1'b0, 4'b1111, 16'h4321);
        tick(1'b0, 4'b1111, 16'h4321);
        tick(1'b1, 4'b1111, 16'h4321);

        // single requester on port 2
        tick(1'b0, 4'b0000, 16'h0000);
        tick(1'b1, 4'b0100, 16'h0100);
        tick(1'b1, 4'b0000, 16'h0100);
        tick(1'b1, 4'b0000, 16'h0100);

        // full rotation with every port requesting
        tick(1'b0, 4'b0000, 16'h0000);
        for (int i = 0; i < 42; i++) tick(1'b1, 4'b1111, 16'hA5C3);

        // back-to-back handoff from port 1 wrapping to port 0
        tick(1'b0, 4'b0000, 16'h0000);
        tick(1'b1, 4'b0010, 16'h00E7);
        tick(1'b1, 4'b0011, 16'h00E7);
        tick(1'b1, 4'b0001, 16'h00E7);
        tick(1'b1, 4'b0001, 16'h00E7);

        // lone owner on port 3 repeatedly hitting the hold limit
        tick(1'b0, 4'b0000, 16'h0000);
        for (int i = 0; i < 20; i++) tick(1'b1, 4'b1000, 16'h9000);

        // reset in the middle of a grant, then arbitrate from ptr 0
        tick(1'b0, 4'b0000, 16'h0000);
        for (int i = 0; i < 6; i++) tick(1'b1, 4'b1000, 16'hB000);
        tick(1'b0, 4'b1000, 16'hB000);
        tick(1'b1, 4'b1010, 16'hB0D0);
        tick(1'b1, 4'b1010, 16'hB0D0);

        // randomized traffic with persistent requests and rare resets
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            dv = 16'($urandom);
            tick(($urandom_range(0, 199) != 0), r, dv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
